// File: rtl/accum_array_rmw_if.sv
// Accumulate and host-read handshake bundle for accum_array_rmw.
// The master side issues requests; the slave side is the counter array.
interface accum_array_rmw_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 64,
    parameter int INC_WIDTH  = 32
);
    logic                  acc_valid;
    logic                  acc_ready;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [INC_WIDTH-1:0]  acc_inc;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_q_valid;
    logic [DATA_WIDTH-1:0] rd_q;

    modport master (
        output acc_valid, acc_addr, acc_inc, rd_valid, rd_addr,
        input  acc_ready, rd_ready, rd_q_valid, rd_q
    );

    modport slave (
        input  acc_valid, acc_addr, acc_inc, rd_valid, rd_addr,
        output acc_ready, rd_ready, rd_q_valid, rd_q
    );
endinterface

// File: rtl/accum_array_rmw.sv
// Accumulate-in-place counter array: 2-stage read-modify-write at one update per cycle,
// with write forwarding, host read port, bulk clear engine and sticky overflow flag.
module accum_array_rmw #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 64,
    parameter int INC_WIDTH  = 32,
    parameter int SATURATE   = 0,
    parameter int AUTO_CLEAR = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_kick_i,
    output logic clear_busy_o,
    output logic overflow_o,
    accum_array_rmw_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {S_IDLE, S_CLEAR} clr_state_e;

    clr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  busy_q;
    logic                  start_q;
    logic                  overflow_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [ADDR_WIDTH-1:0] ram_raddr;

    logic                  s1_valid_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [INC_WIDTH-1:0]  s1_inc_q;

    logic                  fwd_valid_q;
    logic [ADDR_WIDTH-1:0] fwd_addr_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    logic                  rdp_valid_q;
    logic [ADDR_WIDTH-1:0] rdp_addr_q;
    logic [DATA_WIDTH-1:0] rd_hold_q;

    logic                  kick_req, kick_go;
    logic                  acc_fire, rd_fire;
    logic [DATA_WIDTH-1:0] base_d, result_d, rd_base_d;
    logic [DATA_WIDTH:0]   sum_d;
    logic                  carry_d;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    // The post-reset auto-start behaves exactly like an external kick.
    assign kick_req      = clear_kick_i || start_q;
    assign kick_go       = kick_req && (state_q == S_IDLE);
    assign bus.acc_ready = !reset && !busy_q && !kick_req;
    assign bus.rd_ready  = !reset && !busy_q && !kick_req && !bus.acc_valid;
    assign acc_fire      = bus.acc_valid && bus.acc_ready;
    assign rd_fire       = bus.rd_valid && bus.rd_ready;
    assign ram_raddr     = acc_fire ? bus.acc_addr : bus.rd_addr;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        base_d    = ram_q;
        rd_base_d = ram_q;
        if (fwd_valid_q && (fwd_addr_q == s1_addr_q)) base_d = fwd_data_q;
        if (fwd_valid_q && (fwd_addr_q == rdp_addr_q)) rd_base_d = fwd_data_q;
        sum_d    = {1'b0, base_d} + {1'b0, DATA_WIDTH'(s1_inc_q)};
        carry_d  = sum_d[DATA_WIDTH];
        result_d = sum_d[DATA_WIDTH-1:0];
        if (carry_d && (SATURATE != 0)) result_d = '1;
    end

    // Clear writes and stage-1 writes never overlap: no request is accepted while busy.
    assign we    = busy_q || s1_valid_q;
    assign waddr = busy_q ? clr_addr_q : s1_addr_q;
    assign wdata = busy_q ? '0 : result_d;

    // NOTE: the RAM array has no reset; contents are initialised by the clear engine.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        ram_q <= mem[ram_raddr];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            clr_addr_q <= '0;
            start_q    <= (AUTO_CLEAR != 0);
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (kick_go) begin
                        state_q    <= S_CLEAR;
                        busy_q     <= 1'b1;
                        clr_addr_q <= '0;
                    end
                end
                S_CLEAR: begin
                    clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
                    if (clr_addr_q == '1) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            fwd_valid_q <= 1'b0;
            rdp_valid_q <= 1'b0;
            rd_hold_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            s1_valid_q <= acc_fire;
            if (acc_fire) begin
                s1_addr_q <= bus.acc_addr;
                s1_inc_q  <= bus.acc_inc;
            end
            fwd_valid_q <= s1_valid_q && !kick_go;
            fwd_addr_q  <= s1_addr_q;
            fwd_data_q  <= result_d;
            rdp_valid_q <= rd_fire;
            if (rd_fire) rdp_addr_q <= bus.rd_addr;
            if (rdp_valid_q) rd_hold_q <= rd_base_d;
            if (kick_go) overflow_q <= 1'b0;
            else if (s1_valid_q && carry_d) overflow_q <= 1'b1;
        end
    end

    assign bus.rd_q_valid = rdp_valid_q;
    assign bus.rd_q       = rdp_valid_q ? rd_base_d : rd_hold_q;
    assign clear_busy_o   = busy_q;
    assign overflow_o     = overflow_q;
endmodule
